// File: rtl/pos_cache_stream_reader.sv
// ---------------------------------------------------------------------------
// pos_cache_stream_reader
//
// Purpose:
//   Reads one cell's position cache and streams its particles to the force
//   pipeline. On an accepted start it reads the particle count at cache
//   address 0. It then reads addresses 1..N and presents each position word,
//   tagged with its address, on a valid/ready interface. Backpressure is
//   honoured through a 3-entry output FIFO. Read issue is credit-limited, so
//   the FIFO can never overflow and the stream sustains one particle per
//   cycle while the consumer is ready.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              1-cycle request to stream the active cell
//   motion_update_en   cache buffers swapping; aborts an active stream
//   out_rd_addr        cache read address (registered)
//   out_rden           cache read enable (registered)
//   in_particle_info   cache read data, valid the cycle after out_rden
//   out_pos/out_id     FIFO head position word and particle address
//   out_valid/in_ready output handshake
//   out_last           head is the last particle of the cell
//   busy               stream in progress
//   done               1-cycle pulse after the final handshake
//   particle_count     latched, clipped particle count
//   err_overflow       sticky: count exceeded PARTICLE_NUM (cleared on start)
//   err_abort          1-cycle pulse: stream aborted by motion_update_en
// ---------------------------------------------------------------------------
module pos_cache_stream_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      motion_update_en,
    output logic [ADDR_WIDTH-1:0]     out_rd_addr,
    output logic                      out_rden,
    input  logic [3*DATA_WIDTH-1:0]   in_particle_info,
    output logic [3*DATA_WIDTH-1:0]   out_pos,
    output logic [ADDR_WIDTH-1:0]     out_id,
    output logic                      out_valid,
    input  logic                      in_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH-1:0]     particle_count,
    output logic                      err_overflow,
    output logic                      err_abort
);

    localparam int PW    = 3 * DATA_WIDTH;
    localparam int DEPTH = 3;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_NUM,
        S_WAIT_NUM,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic                    r_rden;
    logic                    r_inflight;
    logic [ADDR_WIDTH-1:0]   r_infl_id;
    logic [ADDR_WIDTH:0]     r_next_addr;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err_ovf;
    logic                    r_err_abort;

    logic [PW-1:0]           r_mem_pos [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_mem_id  [DEPTH];
    logic [1:0]              r_wr_ptr;
    logic [1:0]              r_rd_ptr;
    logic [1:0]              r_occ;

    logic                    w_valid;
    logic [ADDR_WIDTH-1:0]   w_head_id;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_abort;
    logic [ADDR_WIDTH-1:0]   w_raw_cnt;
    logic                    w_cnt_ovf;
    logic [ADDR_WIDTH-1:0]   w_cnt_clip;
    logic [2:0]              w_credit;
    logic                    w_can_issue;
    logic                    w_last_hs;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_valid    = (r_occ != 2'd0);
    assign w_head_id  = r_mem_id[r_rd_ptr];
    assign w_pop      = w_valid && in_ready;
    // The count read (address 0) returns while in WAIT_NUM and must not be pushed.
    assign w_push     = (r_state == S_STREAM) && r_inflight;
    assign w_abort    = motion_update_en &&
                        ((r_state == S_RD_NUM) || (r_state == S_WAIT_NUM) || (r_state == S_STREAM));

    assign w_raw_cnt  = in_particle_info[ADDR_WIDTH-1:0];
    assign w_cnt_ovf  = (w_raw_cnt > MAX_CNT);
    assign w_cnt_clip = w_cnt_ovf ? MAX_CNT : w_raw_cnt;

    // Slots committed after this edge: FIFO contents (including the word
    // returning now, less any pop) plus the read on the port this cycle.
    // A new read is issued only if it still fits in the FIFO.
    assign w_credit    = {1'b0, r_occ} + {2'b0, r_inflight} + {2'b0, r_rden} - {2'b0, w_pop};
    assign w_can_issue = (r_next_addr <= {1'b0, r_cnt}) && (w_credit < 3'd3);
    assign w_last_hs   = w_pop && (w_head_id == r_cnt);

    // Control FSM and read issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_rden      <= 1'b0;
            r_inflight  <= 1'b0;
            r_infl_id   <= '0;
            r_next_addr <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            r_rden      <= 1'b0;
            r_done      <= 1'b0;
            r_err_abort <= 1'b0;
            r_inflight  <= r_rden;
            r_infl_id   <= r_rd_addr;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_err_abort <= 1'b1;
                r_inflight  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !motion_update_en) begin
                            r_state   <= S_RD_NUM;
                            r_busy    <= 1'b1;
                            r_err_ovf <= 1'b0;
                            r_rden    <= 1'b1;
                            r_rd_addr <= '0;
                        end
                    end
                    S_RD_NUM: begin
                        r_state <= S_WAIT_NUM;
                    end
                    S_WAIT_NUM: begin
                        r_cnt <= w_cnt_clip;
                        if (w_cnt_ovf) begin
                            r_err_ovf <= 1'b1;
                        end
                        if (w_cnt_clip == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_STREAM;
                            r_rden      <= 1'b1;
                            r_rd_addr   <= ADDR_WIDTH'(1);
                            r_next_addr <= (ADDR_WIDTH+1)'(2);
                        end
                    end
                    S_STREAM: begin
                        if (w_can_issue) begin
                            r_rden      <= 1'b1;
                            r_rd_addr   <= r_next_addr[ADDR_WIDTH-1:0];
                            r_next_addr <= r_next_addr + 1'b1;
                        end
                        if (w_last_hs) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        // A start arriving in the done cycle is deliberately dropped.
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Output FIFO: pointers/occupancy are reset, payload storage is not.
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_abort) begin
            r_mem_pos[r_wr_ptr] <= in_particle_info;
            r_mem_id[r_wr_ptr]  <= r_infl_id;
        end
    end

    // The credit scheme must make these impossible.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && (r_occ == 2'd3)));
            assert (!(w_pop && (r_occ == 2'd0)));
        end
    end

    // Payload is masked while empty so every output reads 0 out of reset.
    assign out_valid      = w_valid;
    assign out_pos        = w_valid ? r_mem_pos[r_rd_ptr] : '0;
    assign out_id         = w_valid ? w_head_id : '0;
    assign out_last       = w_valid && (w_head_id == r_cnt);
    assign out_rd_addr    = r_rd_addr;
    assign out_rden       = r_rden;
    assign busy           = r_busy;
    assign done           = r_done;
    assign particle_count = r_cnt;
    assign err_overflow   = r_err_ovf;
    assign err_abort      = r_err_abort;

endmodule

// File: tb/tb_pos_cache_stream_reader.sv
module tb_pos_cache_stream_reader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int PW = 3 * DW;

    logic           clk;
    logic           rst;
    logic           start;
    logic           motion_update_en;
    logic [AW-1:0]  out_rd_addr;
    logic           out_rden;
    logic [PW-1:0]  in_particle_info;
    logic [PW-1:0]  out_pos;
    logic [AW-1:0]  out_id;
    logic           out_valid;
    logic           in_ready;
    logic           out_last;
    logic           busy;
    logic           done;
    logic [AW-1:0]  particle_count;
    logic           err_overflow;
    logic           err_abort;

    int n_checks;
    int n_errors;

    logic [PW-1:0] cache [256];

    // Per-stream record filled by collect().
    int            hs_n;
    int            hs_id   [256];
    logic [PW-1:0] hs_pos  [256];
    bit            hs_last [256];
    int            hs_cyc  [256];
    int            rd_n;
    int            rd_addr [256];
    int            rd_cyc  [256];
    int            done_cyc;
    bit            valid_seen;
    int            stab_err;
    int            credit_err;

    pos_cache_stream_reader #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .PARTICLE_NUM(220)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .motion_update_en(motion_update_en),
        .out_rd_addr     (out_rd_addr),
        .out_rden        (out_rden),
        .in_particle_info(in_particle_info),
        .out_pos         (out_pos),
        .out_id          (out_id),
        .out_valid       (out_valid),
        .in_ready        (in_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done),
        .particle_count  (particle_count),
        .err_overflow    (err_overflow),
        .err_abort       (err_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: one-cycle read latency.
    initial in_particle_info = '0;
    always @(posedge clk) begin
        if (out_rden) in_particle_info <= cache[out_rd_addr];
    end

    function automatic logic [PW-1:0] pos_of(input int a);
        return {32'hC000_0000 | 32'(a), 32'hB000_0000 | 32'(a), 32'hA000_0000 | 32'(a)};
    endfunction

    task automatic load_cache(input int cnt);
        cache[0] = PW'(cnt);
        for (int a = 1; a < 256; a++) cache[a] = pos_of(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns 1 ns into the cycle after acceptance.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs the consumer side until done, recording reads and handshakes.
    // Cycle index 1 is the cycle right after start was sampled.
    task automatic collect(input int max_cyc, input bit rnd);
        logic          pv, pr, plast;
        logic [PW-1:0] ppos;
        logic [AW-1:0] pid;
        hs_n = 0; rd_n = 0; done_cyc = -1; valid_seen = 0;
        stab_err = 0; credit_err = 0;
        pv = 0; pr = 0; plast = 0; ppos = '0; pid = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (out_rden && rd_n < 256) begin
                rd_addr[rd_n] = int'(out_rd_addr);
                rd_cyc[rd_n]  = c;
                rd_n++;
            end
            if (out_valid) valid_seen = 1;
            if (pv && !pr) begin
                if (!out_valid || out_pos !== ppos || out_id !== pid || out_last !== plast)
                    stab_err++;
            end
            if (int'(dut.r_occ) + int'(dut.r_inflight) > 3) credit_err++;
            if (done) begin
                done_cyc = c;
                in_ready = 1'b0;
                break;
            end
            in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && in_ready && hs_n < 256) begin
                hs_id[hs_n]   = int'(out_id);
                hs_pos[hs_n]  = out_pos;
                hs_last[hs_n] = out_last;
                hs_cyc[hs_n]  = c;
                hs_n++;
            end
            pv = out_valid; pr = in_ready; ppos = out_pos; pid = out_id; plast = out_last;
            step();
        end
        in_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; motion_update_en = 1'b0; in_ready = 1'b0;
        step(); step();
        n_checks++;
        if ({out_rd_addr, out_rden, out_pos, out_id, out_valid, out_last, busy, done,
             particle_count, err_overflow, err_abort} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%0b busy=%0b rden=%0b addr=%0d cnt=%0d expected all 0",
                     out_valid, busy, out_rden, out_rd_addr, particle_count);
        end
        rst = 1'b0;
        step();
        // start while buffers are swapping must be ignored
        load_cache(3);
        start = 1'b1; motion_update_en = 1'b1;
        step();
        start = 1'b0; motion_update_en = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_rden !== 1'b0) begin
            n_errors++;
            $display("FAIL start_blocked: got busy=%0b rden=%0b expected 0 0", busy, out_rden);
        end
        step();
    endtask

    task automatic test_basic();
        int exp_ra [4] = '{0, 1, 2, 3};
        int exp_rc [4] = '{1, 3, 4, 5};
        load_cache(3);
        do_start();
        collect(40, 0);
        n_checks++;
        if (rd_n !== 4) begin
            n_errors++; $display("FAIL basic_read_count: got %0d expected 4", rd_n);
        end
        for (int i = 0; i < 4 && i < rd_n; i++) begin
            n_checks++;
            if (rd_addr[i] !== exp_ra[i] || rd_cyc[i] !== exp_rc[i]) begin
                n_errors++;
                $display("FAIL basic_read[%0d]: got addr=%0d cyc=%0d expected addr=%0d cyc=%0d",
                         i, rd_addr[i], rd_cyc[i], exp_ra[i], exp_rc[i]);
            end
        end
        n_checks++;
        if (hs_n !== 3) begin
            n_errors++; $display("FAIL basic_hs_count: got %0d expected 3", hs_n);
        end
        for (int i = 0; i < 3 && i < hs_n; i++) begin
            n_checks++;
            if (hs_id[i] !== i + 1 || hs_pos[i] !== pos_of(i + 1) || hs_cyc[i] !== 5 + i ||
                hs_last[i] !== (i == 2)) begin
                n_errors++;
                $display("FAIL basic_hs[%0d]: got id=%0d cyc=%0d last=%0b pos=%h expected id=%0d cyc=%0d last=%0b pos=%h",
                         i, hs_id[i], hs_cyc[i], hs_last[i], hs_pos[i], i + 1, 5 + i, (i == 2), pos_of(i + 1));
            end
        end
        n_checks++;
        if (done_cyc !== 8 || busy !== 1'b0 || out_valid !== 1'b0 || particle_count !== 8'd3) begin
            n_errors++;
            $display("FAIL basic_done: got done_cyc=%0d busy=%0b valid=%0b cnt=%0d expected 8 0 0 3",
                     done_cyc, busy, out_valid, particle_count);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++; $display("FAIL basic_done_pulse: got done=%0b expected 0", done);
        end
    endtask

    task automatic test_zero_count();
        load_cache(0);
        do_start();
        n_checks++;
        if (busy !== 1'b1 || out_rden !== 1'b1 || out_rd_addr !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_t1: got busy=%0b rden=%0b addr=%0d expected 1 1 0", busy, out_rden, out_rd_addr);
        end
        step();
        n_checks++;
        if (busy !== 1'b1 || out_rden !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_t2: got busy=%0b rden=%0b done=%0b expected 1 0 0", busy, out_rden, done);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_rden !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_t3: got done=%0b busy=%0b valid=%0b rden=%0b expected 1 0 0 0",
                     done, busy, out_valid, out_rden);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || particle_count !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_after: got done=%0b valid=%0b cnt=%0d expected 0 0 0", done, out_valid, particle_count);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        load_cache(8);
        do_start();
        collect(200, 1);
        bad = 0;
        for (int i = 0; i < hs_n; i++) begin
            if (hs_id[i] !== i + 1 || hs_pos[i] !== pos_of(i + 1) || hs_last[i] !== (i == 7)) bad++;
        end
        n_checks++;
        if (hs_n !== 8 || bad !== 0) begin
            n_errors++;
            $display("FAIL bp_sequence: got count=%0d bad=%0d expected count=8 bad=0", hs_n, bad);
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_errors++; $display("FAIL bp_stable: got %0d changes under stall expected 0", stab_err);
        end
        n_checks++;
        if (credit_err !== 0) begin
            n_errors++; $display("FAIL bp_credit: got %0d cycles over 3 expected 0", credit_err);
        end
        n_checks++;
        if (done_cyc < 0 || valid_seen !== 1'b1) begin
            n_errors++; $display("FAIL bp_done: got done_cyc=%0d expected completion", done_cyc);
        end
        step();
    endtask

    task automatic test_overflow();
        load_cache(250);
        do_start();
        collect(600, 0);
        n_checks++;
        if (particle_count !== 8'd220 || err_overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_clip: got cnt=%0d err=%0b expected 220 1", particle_count, err_overflow);
        end
        n_checks++;
        if (hs_n !== 220 || done_cyc < 0) begin
            n_errors++; $display("FAIL ovf_count: got %0d done_cyc=%0d expected 220 done", hs_n, done_cyc);
        end else begin
            n_checks++;
            if (hs_id[219] !== 220 || hs_last[219] !== 1'b1 || hs_last[218] !== 1'b0 ||
                hs_cyc[219] - hs_cyc[0] !== 219) begin
                n_errors++;
                $display("FAIL ovf_last: got id=%0d last=%0b span=%0d expected 220 1 219",
                         hs_id[219], hs_last[219], hs_cyc[219] - hs_cyc[0]);
            end
        end
        step();
        n_checks++;
        if (err_overflow !== 1'b1) begin
            n_errors++; $display("FAIL ovf_sticky: got %0b expected 1", err_overflow);
        end
    endtask

    task automatic test_abort();
        int  n;
        bit  got;
        load_cache(10);
        do_start();
        n_checks++;
        if (err_overflow !== 1'b0) begin
            n_errors++; $display("FAIL abort_ovf_clear: got %0b expected 0", err_overflow);
        end
        n = 0; got = 0;
        for (int c = 0; c < 60; c++) begin
            in_ready = 1'b1;
            if (out_valid) n++;
            step();
            if (n == 4) begin got = 1; break; end
        end
        n_checks++;
        if (!got) begin
            n_errors++; $display("FAIL abort_reach4: got %0d handshakes expected 4", n);
        end
        motion_update_en = 1'b1;
        step();
        motion_update_en = 1'b0;
        in_ready = 1'b0;
        n_checks++;
        if (err_abort !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_pulse: got abort=%0b valid=%0b busy=%0b done=%0b expected 1 0 0 0",
                     err_abort, out_valid, busy, done);
        end
        got = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done || out_valid || busy || err_abort) got = 1;
        end
        n_checks++;
        if (got) begin
            n_errors++; $display("FAIL abort_quiet: got activity after abort expected none");
        end
        do_start();
        collect(80, 0);
        n = 0;
        for (int i = 0; i < hs_n; i++) if (hs_id[i] !== i + 1 || hs_pos[i] !== pos_of(i + 1)) n++;
        n_checks++;
        if (hs_n !== 10 || n !== 0 || done_cyc < 0) begin
            n_errors++;
            $display("FAIL abort_restream: got count=%0d bad=%0d done_cyc=%0d expected 10 0 done",
                     hs_n, n, done_cyc);
        end
        step();
    endtask

    task automatic test_rst_mid();
        load_cache(10);
        do_start();
        in_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_ready = 1'b0;
        n_checks++;
        if ({out_rd_addr, out_rden, out_pos, out_id, out_valid, out_last, busy, done,
             particle_count, err_overflow, err_abort} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid: got valid=%0b busy=%0b rden=%0b addr=%0d cnt=%0d id=%0d expected all 0",
                     out_valid, busy, out_rden, out_rd_addr, particle_count, out_id);
        end
        step();
    endtask

    task automatic test_start_on_done();
        load_cache(3);
        do_start();
        collect(40, 0);
        n_checks++;
        if (done_cyc !== 8) begin
            n_errors++; $display("FAIL sod_done: got done_cyc=%0d expected 8", done_cyc);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_rden !== 1'b0) begin
            n_errors++; $display("FAIL sod_ignored: got busy=%0b rden=%0b expected 0 0", busy, out_rden);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL sod_idle: got busy=%0b valid=%0b expected 0 0", busy, out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_overflow();
        test_abort();
        test_rst_mid();
        test_start_on_done();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
